// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to a 2R1W register file
// with write-first bypass on both read ports, and counts retired instructions.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_ctrl_toReg,
  input  logic              wb_ctrl_regWrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_rdata,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [CNT_W-1:0]  retired_count
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regFile_r [0:NREG-1];
  logic [CNT_W-1:0]  retiredCount_r;
  logic [DATA_W-1:0] wbWdata_s;
  logic              wbWe_s;
  logic [DATA_W-1:0] rs1Data_s;
  logic [DATA_W-1:0] rs2Data_s;

  // Writeback source select and effective write enable (x0 is never a target).
  always_comb begin
    wbWdata_s = wb_alu_result;
    wbWe_s    = 1'b0;
    if (wb_ctrl_toReg) begin
      wbWdata_s = wb_mem_rdata;
    end else begin
      wbWdata_s = wb_alu_result;
    end
    if (wb_valid && wb_ctrl_regWrite && (wb_rd != {ADDR_W{1'b0}})) begin
      wbWe_s = 1'b1;
    end else begin
      wbWe_s = 1'b0;
    end
  end

  // Register storage and retired-instruction counter; reset discards any in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
      end
      retiredCount_r <= {CNT_W{1'b0}};
    end else begin
      if (wbWe_s) begin
        regFile_r[wb_rd] <= wbWdata_s;
      end
      if (wb_valid) begin
        retiredCount_r <= retiredCount_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read port 1: x0 first, then write-first bypass, then storage.
  always_comb begin
    rs1Data_s = {DATA_W{1'b0}};
    if (rs1_addr == {ADDR_W{1'b0}}) begin
      rs1Data_s = {DATA_W{1'b0}};
    end else if (wbWe_s && (wb_rd == rs1_addr)) begin
      rs1Data_s = wbWdata_s;
    end else begin
      rs1Data_s = regFile_r[rs1_addr];
    end
  end

  // Read port 2: same priority as port 1, fully independent.
  always_comb begin
    rs2Data_s = {DATA_W{1'b0}};
    if (rs2_addr == {ADDR_W{1'b0}}) begin
      rs2Data_s = {DATA_W{1'b0}};
    end else if (wbWe_s && (wb_rd == rs2_addr)) begin
      rs2Data_s = wbWdata_s;
    end else begin
      rs2Data_s = regFile_r[rs2_addr];
    end
  end

  assign rs1_data      = rs1Data_s;
  assign rs2_data      = rs2Data_s;
  assign wb_wdata      = wbWdata_s;
  assign wb_we         = wbWe_s;
  assign wb_waddr      = wb_rd;
  assign retired_count = retiredCount_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed + random stimulus against an array model;
// a second instance with a 4-bit counter exercises counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0, wb_ctrl_toReg = 1'b0, wb_ctrl_regWrite = 1'b0;
  logic [4:0]  wb_rd = 5'd0, rs1_addr = 5'd0, rs2_addr = 5'd0;
  logic [31:0] wb_alu_result = 32'd0, wb_mem_rdata = 32'd0;

  logic [31:0] rs1_data, rs2_data, wb_wdata, retired_count;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] rs1_data4, rs2_data4, wb_wdata4;
  logic        wb_we4;
  logic [4:0]  wb_waddr4;
  logic [3:0]  retired_count4;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ctrl_toReg(wb_ctrl_toReg),
    .wb_ctrl_regWrite(wb_ctrl_regWrite), .wb_rd(wb_rd), .wb_alu_result(wb_alu_result),
    .wb_mem_rdata(wb_mem_rdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .retired_count(retired_count));

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ctrl_toReg(wb_ctrl_toReg),
    .wb_ctrl_regWrite(wb_ctrl_regWrite), .wb_rd(wb_rd), .wb_alu_result(wb_alu_result),
    .wb_mem_rdata(wb_mem_rdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data4), .rs2_data(rs2_data4), .wb_wdata(wb_wdata4), .wb_we(wb_we4),
    .wb_waddr(wb_waddr4), .retired_count(retired_count4));

  typedef struct {
    int          id;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expQ[$];
  int          nChecks = 0;
  int          nPass = 0;
  int          stepId = 0;
  logic [31:0] mRegs [0:31];
  logic [31:0] mCnt;

  task automatic check(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s step=%0d got=%h expected=%h", nm, id, got, exp);
  endtask

  // Monitor: outputs are combinational, so each negedge presents one result to score.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("rs1_data", e.id, rs1_data, e.rs1);
      check("rs2_data", e.id, rs2_data, e.rs2);
      check("wb_wdata", e.id, wb_wdata, e.wd);
      check("wb_we", e.id, {31'd0, wb_we}, {31'd0, e.we});
      check("wb_waddr", e.id, {27'd0, wb_waddr}, {27'd0, e.wa});
      check("retired_count", e.id, retired_count, e.cnt);
      check("rs1_data_c4", e.id, rs1_data4, e.rs1);
      check("rs2_data_c4", e.id, rs2_data4, e.rs2);
      check("retired_count_c4", e.id, {28'd0, retired_count4}, {28'd0, e.cnt[3:0]});
    end
  end

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mCnt = 32'd0;
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a, input logic we,
                                            input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && (rd == a)) return wd;
    return mRegs[a];
  endfunction

  // One cycle: drive inputs just after posedge, queue expectation, then commit model at edge.
  task automatic step(input logic rst, input logic v, input logic tr, input logic rw,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t        e;
    logic [31:0] wd;
    logic        we;
    reset = rst; wb_valid = v; wb_ctrl_toReg = tr; wb_ctrl_regWrite = rw;
    wb_rd = rd; wb_alu_result = alu; wb_mem_rdata = mem; rs1_addr = a1; rs2_addr = a2;
    if (rst) clearModel();
    wd = tr ? mem : alu;
    we = v && rw && (rd != 5'd0);
    e.id  = stepId;
    e.rs1 = modelRead(a1, we, rd, wd);
    e.rs2 = modelRead(a2, we, rd, wd);
    e.wd  = wd;
    e.we  = we;
    e.wa  = rd;
    e.cnt = mCnt;
    expQ.push_back(e);
    stepId++;
    @(posedge clk);
    if (!rst) begin
      if (we) mRegs[rd] = wd;
      if (v) mCnt = mCnt + 32'd1;
    end else begin
      clearModel();
    end
    #1;
  endtask

  initial begin
    clearModel();
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    // Post-reset: all indices read zero on both ports.
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, i[4:0], 5'(31 - i));
    // ALU write to x5, load write to x6, then read both back.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0BAD_0BAD, 5'd1, 5'd2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1111_1111, 32'hDEAD_BEEF, 5'd5, 5'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd6);
    // Same-cycle bypass to x7 on both ports, then from storage.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 32'd0, 5'd7, 5'd7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7);
    // Write to x0 never lands or bypasses.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd5);
    // Bubble with write controls set: no write, no bypass, no count.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h55, 32'h55, 5'd3, 5'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3);
    // 10 valid (mixed write/non-write) plus 3 bubbles.
    for (int i = 0; i < 13; i++)
      step(1'b0, (i % 4) != 3, 1'b0, i[0], 5'(i + 8), 32'hA000_0000 + i, 32'd0, 5'(i + 7), 5'(i + 8));
    // Randomized stream, with collisions favoured and occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd, a1, a2;
      rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom), rd, $urandom, $urandom, a1, a2);
    end
    // Reset asserted with a valid write in flight: discarded, everything reads zero.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h9999_9999, 32'd0, 5'd9, 5'd5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h1010_1010, 32'd0, 5'd9, 5'd11);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd6);
    @(negedge clk);
    @(negedge clk);
    nChecks++;
    if (expQ.size() == 0) nPass++;
    else $display("FAIL scoreboard_drain pending=%0d expected=0", expQ.size());
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
